// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request, one-deep
// output register towards decode, redirect/drain handling and PC fault trap.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        fault_o
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    VALID,
    DRAIN,
    FAULT
  } state_t;

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pco_q, pco_d;
  logic        fault_q, fault_d;
  logic        go;
  logic [31:0] go_pc;

  function automatic logic bad_pc(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= MEM_LIMIT);
  endfunction

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    instr_d = instr_q;
    pco_d   = pco_q;
    fault_d = fault_q;
    go      = 1'b0;
    go_pc   = pc_q;
    unique case (state_q)
      IDLE: begin
        go = 1'b1;
        if (redirect_i) begin
          pc_d  = redirect_pc_i;
          go_pc = redirect_pc_i;
        end
      end
      REQ: begin
        if (redirect_i) begin
          pc_d = redirect_pc_i;
          if (mem_ack_i) begin
            go    = 1'b1;
            go_pc = redirect_pc_i;
          end else begin
            state_d = DRAIN;
          end
        end else if (mem_ack_i) begin
          state_d = VALID;
          req_d   = 1'b0;
          valid_d = 1'b1;
          instr_d = mem_rdata_i;
          pco_d   = pc_q;
          pc_d    = pc_q + 32'd4;
        end
      end
      VALID: begin
        if (redirect_i) begin
          valid_d = 1'b0;
          pc_d    = redirect_pc_i;
          go      = 1'b1;
          go_pc   = redirect_pc_i;
        end else if (!stall_i) begin
          valid_d = 1'b0;
          go      = 1'b1;
        end
      end
      DRAIN: begin
        // the in-flight request keeps its old address; only pc_reg moves
        if (redirect_i) pc_d = redirect_pc_i;
        if (mem_ack_i) begin
          go    = 1'b1;
          go_pc = redirect_i ? redirect_pc_i : pc_q;
        end
      end
      FAULT: begin
        if (redirect_i) begin
          pc_d  = redirect_pc_i;
          go    = 1'b1;
          go_pc = redirect_pc_i;
        end
      end
      default: state_d = IDLE;
    endcase
    if (go) begin
      if (bad_pc(go_pc)) begin
        state_d = FAULT;
        req_d   = 1'b0;
        fault_d = 1'b1;
        pco_d   = go_pc;
      end else begin
        state_d = REQ;
        req_d   = 1'b1;
        addr_d  = go_pc;
        fault_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      instr_q <= '0;
      pco_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pco_q   <= pco_d;
      fault_q <= fault_d;
    end
  end

  assign mem_req_o     = req_q;
  assign mem_addr_o    = addr_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign pc_o          = pco_q;
  assign fault_o       = fault_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized scoreboard bench for fetch_ctrl plus a small-memory
// sequential run that walks off the end of memory.
module tb_fetch_ctrl;

  localparam int          MW     = 32;
  localparam logic [31:0] RST_PC = 32'h0;
  localparam int          NCYC   = 4000;

  logic        clk = 1'b0;
  logic        rst, stall_i, redirect_i, mem_ack_i;
  logic [31:0] redirect_pc_i, mem_rdata_i;
  logic        mem_req_o, instr_valid_o, fault_o;
  logic [31:0] mem_addr_o, instr_o, pc_o;

  logic        rst4, q4, v4, f4;
  logic [31:0] a4, i4, p4, d4;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(RST_PC), .MEM_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o),
    .pc_o(pc_o), .fault_o(fault_o)
  );

  assign d4 = a4 ^ 32'hA5A5_0000;

  fetch_ctrl #(.RESET_PC(32'h0), .MEM_WORDS(4)) dut4 (
    .clk(clk), .rst(rst4), .stall_i(1'b0),
    .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .mem_req_o(q4), .mem_addr_o(a4),
    .mem_ack_i(q4), .mem_rdata_i(d4),
    .instr_valid_o(v4), .instr_o(i4),
    .pc_o(p4), .fault_o(f4)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [31:0] mem [MW];
  int          tests = 0, fails = 0;
  int          cyc = 0, offers = 0, faults = 0;
  logic [31:0] e, sa, e_now = '0, sa_now = '0;
  logic        stale, stale_now = 1'b0;
  logic        prev_rst = 1'b1, prev_valid = 1'b0, must_drop = 1'b0;
  logic        fin = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic bad(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= MW);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // driver + reference model
  initial begin
    logic [31:0] tgt;
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0;
    redirect_pc_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    foreach (mem[i]) mem[i] = $urandom;
    e = RST_PC; stale = 1'b0; sa = '0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk); #2;
      e_now = e; stale_now = stale; sa_now = sa;
      rst = (c < 2) || (c >= 30 && ($urandom_range(99) == 0 ||
            (stale && mem_req_o && $urandom_range(4) == 0)));
      if (c < 30) begin
        mem_ack_i = mem_req_o; stall_i = 1'b0; redirect_i = 1'b0;
      end else begin
        mem_ack_i = mem_req_o ? ($urandom_range(2) == 0)
                              : ($urandom_range(4) == 0);
        stall_i = 1'($urandom_range(1));
        redirect_i = ($urandom_range(9) == 0);
      end
      case ($urandom_range(3))
        0: tgt = 32'($urandom_range(MW * 4 - 1));
        1: tgt = 32'(MW * 4 + $urandom_range(15) * 4);
        default: tgt = 32'($urandom_range(MW - 1) * 4);
      endcase
      redirect_pc_i = tgt;
      mem_rdata_i = (mem_ack_i && mem_req_o) ? mem[mem_addr_o[6:2]]
                                             : $urandom;
      if (rst) begin
        e = RST_PC; stale = 1'b0;
      end else if (redirect_i) begin
        if (mem_req_o && !mem_ack_i) begin
          if (!stale) sa = e;
          stale = 1'b1;
        end else begin
          stale = 1'b0;
        end
        e = tgt;
      end else if (mem_ack_i && mem_req_o) begin
        if (stale) stale = 1'b0;
        else begin
          sb.push_back('{pc: e, data: mem[e[6:2]], cyc: c + 2});
          e = e + 32'd4;
        end
      end
    end
    rst = 1'b0; redirect_i = 1'b0; mem_ack_i = 1'b0;
    fin = 1'b1;
    repeat (3) @(posedge clk);
    chk("offers_seen", 128'(offers > 50), 128'(1));
    chk("faults_seen", 128'(faults > 0), 128'(1));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // monitor
  always @(negedge clk) begin
    if (cyc >= 2 && !fin) begin
      if (prev_rst)
        chk("reset_state", {mem_req_o, instr_valid_o, fault_o,
                            mem_addr_o, instr_o, pc_o}, '0);
      else
        chk("one_active", 2'(mem_req_o) + 2'(instr_valid_o)
                          + 2'(fault_o), 2'd1);
      if (mem_req_o)
        chk("mem_addr", mem_addr_o, stale_now ? sa_now : e_now);
      if (fault_o) begin
        faults++;
        chk("fault_pc", pc_o, e_now);
        chk("fault_cause", bad(e_now), 1'b1);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        chk("valid_rise", {instr_valid_o, prev_valid}, 2'b10);
        chk("pc_o", pc_o, sb[0].pc);
        chk("instr_o", instr_o, sb[0].data);
        cur = sb.pop_front();
        offers++;
      end else if (instr_valid_o && !prev_valid) begin
        chk("spurious_valid", instr_valid_o, 1'b0);
      end else if (instr_valid_o) begin
        if (must_drop) chk("valid_drop", instr_valid_o, 1'b0);
        else begin
          chk("hold_pc", pc_o, cur.pc);
          chk("hold_instr", instr_o, cur.data);
        end
      end
      must_drop = instr_valid_o && (!stall_i || redirect_i || rst);
      prev_valid = instr_valid_o;
      prev_rst = rst;
    end
  end

  // small memory: sequential walk off the end
  initial begin
    int idx, last;
    logic pv4, done4;
    idx = 0; last = 0; pv4 = 1'b0; done4 = 1'b0;
    rst4 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst4 = 1'b0;
    for (int c = 0; c < 60 && !done4; c++) begin
      @(negedge clk);
      if (q4) chk("m4_addr_range", 128'(a4 < 32'h10), 128'(1));
      if (v4 && !pv4) begin
        chk("m4_pc", p4, 32'(idx * 4));
        chk("m4_instr", i4, 32'(idx * 4) ^ 32'hA5A5_0000);
        if (idx > 0) chk("m4_rate", 32'(c - last), 32'd2);
        last = c;
        idx++;
      end
      if (f4) begin
        chk("m4_count", 32'(idx), 32'd4);
        chk("m4_fault_pc", p4, 32'h10);
        chk("m4_fault_quiet", {q4, v4}, 2'b00);
        done4 = 1'b1;
      end
      pv4 = v4;
    end
    if (!done4) chk("m4_timeout", done4, 1'b1);
  end

endmodule
